rgb565_gray_pipe_ise: RTL

RGB565_GRAY_PIPE_ISE -- requirements
Module: rgb565_gray_pipe_ise

---
 rtl/rgb565_gray_pipe_ise_pkg.sv | 42 ++++
 rtl/rgb565_gray_pipe_ise_if.sv | 18 +
 rtl/rgb565_gray_pixel.sv | 43 ++++
 rtl/rgb565_gray_pipe_ise.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rgb565_gray_pipe_ise_pkg.sv
// rgb565_gray_pkg: shared encodings and constants for the RGB565 grayscale
// custom-instruction pipeline. Optional stats feature: GRAY_STATS_EN.
package rgb565_gray_pkg;

    // Conversion modes selected through the CONFIG opcode
    typedef enum logic [1:0] {
        MODE_BT601  = 2'd0,
        MODE_AVG    = 2'd1,
        MODE_GREEN  = 2'd2,
        MODE_THRESH = 2'd3
    } gray_mode_e;

    // Opcode offsets relative to customInstructionId
    localparam logic [7:0] OPC_CONVERT_OFS = 8'd0;
    localparam logic [7:0] OPC_CONFIG_OFS  = 8'd1;
    localparam logic [7:0] OPC_STATS_OFS   = 8'd2;

    // Decoded operation carried down the pipeline
    typedef enum logic [1:0] {
        OP_CONVERT = 2'd0,
        OP_CONFIG  = 2'd1,
        OP_STATS   = 2'd2
    } op_kind_e;

    // Luma weights (sum to 256) and the divide-by-3 approximation factor
    localparam logic [15:0] BT601_R    = 16'd77;
    localparam logic [15:0] BT601_G    = 16'd150;
    localparam logic [15:0] BT601_B    = 16'd29;
    localparam logic [15:0] AVG_FACTOR = 16'd85;

    localparam logic [7:0] THRESH_RST = 8'h80;

    // One pipeline slot: the gray word is computed at acceptance, so only the
    // STATS readback needs resolving at the final stage.
    typedef struct packed {
        logic        valid;
        op_kind_e    op;
        logic        clr;
        logic [31:0] data;
    } stage_t;

endpackage

// File: rtl/rgb565_gray_pipe_ise_if.sv
// Instruction bus bundle for rgb565_gray_pipe_ise (start/operands in,
// done/result out). Optional stats feature: GRAY_STATS_EN.
//
// Handshake: start is a single-cycle strobe with no backpressure; every
// accepted start (recognised iseId) yields exactly one single-cycle done
// PIPE_DEPTH cycles later, in issue order; result is only meaningful (and
// otherwise zero) while done is high.
interface rgb565_gray_pipe_ise_if;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  iseId;
    logic        done;
    logic [31:0] result;

    modport master (output start, valueA, valueB, iseId, input done, result);
    modport slave  (input start, valueA, valueB, iseId, output done, result);
endinterface

// File: rtl/rgb565_gray_pixel.sv
// rgb565_gray_pixel: combinational RGB565 -> 8-bit gray for one pixel.
// Optional stats feature elsewhere: GRAY_STATS_EN (not used here).
module rgb565_gray_pixel
    import rgb565_gray_pkg::*;
(
    input  logic [15:0] pix_i,
    input  gray_mode_e  mode_i,
    input  logic [7:0]  thresh_i,
    output logic [7:0]  gray_o
);

    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] luma_sum;
    logic [9:0]  avg_sum;
    logic [15:0] avg_prod;
    logic [7:0]  luma;

    // Expand channels by replicating MSBs, then form luma and average
    always_comb begin
        r8       = {pix_i[15:11], pix_i[15:13]};
        g8       = {pix_i[10:5], pix_i[10:9]};
        b8       = {pix_i[4:0], pix_i[4:2]};
        luma_sum = BT601_R * {8'h00, r8} + BT601_G * {8'h00, g8} + BT601_B * {8'h00, b8};
        luma     = luma_sum[15:8];
        avg_sum  = {2'b00, r8} + {2'b00, g8} + {2'b00, b8};
        avg_prod = {6'd0, avg_sum} * AVG_FACTOR;
    end

    // Select the output according to the mode
    always_comb begin
        gray_o = luma;
        case (mode_i)
            MODE_BT601:  gray_o = luma;
            MODE_AVG:    gray_o = avg_prod[15:8];
            MODE_GREEN:  gray_o = g8;
            MODE_THRESH: gray_o = (luma >= thresh_i) ? 8'hFF : 8'h00;
            default:     gray_o = luma;
        endcase
    end

endmodule

// File: rtl/rgb565_gray_pipe_ise.sv
// rgb565_gray_pipe_ise: four-pixel RGB565 grayscale custom instruction with a
// fixed PIPE_DEPTH-cycle latency. Define GRAY_STATS_EN to build the gray-byte
// accumulator and STATS readback; without it STATS completes with result 0.
module rgb565_gray_pipe_ise
    import rgb565_gray_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         PIPE_DEPTH          = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  iseId,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [7:0] ID_CONVERT = customInstructionId + OPC_CONVERT_OFS;
    localparam logic [7:0] ID_CONFIG  = customInstructionId + OPC_CONFIG_OFS;
    localparam logic [7:0] ID_STATS   = customInstructionId + OPC_STATS_OFS;

    gray_mode_e  mode_q, mode_d;
    logic [7:0]  thresh_q, thresh_d;
    stage_t      stg_q [PIPE_DEPTH];
    stage_t      stg_d;
    stage_t      fin;
    logic        is_convert, is_config, is_stats;
    logic [7:0]  gray0, gray1, gray2, gray3;
    logic [31:0] result_c;

    // Opcode decode; unknown ids and idle cycles are ignored
    always_comb begin
        is_convert = start && (iseId == ID_CONVERT);
        is_config  = start && (iseId == ID_CONFIG);
        is_stats   = start && (iseId == ID_STATS);
    end

    // Pixels use the settings registered before this cycle, so a CONFIG only
    // affects ops accepted after it
    rgb565_gray_pixel u_pix0 (.pix_i(valueA[15:0]),  .mode_i(mode_q), .thresh_i(thresh_q), .gray_o(gray0));
    rgb565_gray_pixel u_pix1 (.pix_i(valueA[31:16]), .mode_i(mode_q), .thresh_i(thresh_q), .gray_o(gray1));
    rgb565_gray_pixel u_pix2 (.pix_i(valueB[15:0]),  .mode_i(mode_q), .thresh_i(thresh_q), .gray_o(gray2));
    rgb565_gray_pixel u_pix3 (.pix_i(valueB[31:16]), .mode_i(mode_q), .thresh_i(thresh_q), .gray_o(gray3));

    // Build the entry slot for the op accepted this cycle
    always_comb begin
        stg_d       = '0;
        stg_d.valid = is_convert || is_config || is_stats;
        stg_d.clr   = valueA[0];
        if (is_convert) begin
            stg_d.op   = OP_CONVERT;
            stg_d.data = {gray3, gray2, gray1, gray0};
        end else if (is_config) begin
            stg_d.op = OP_CONFIG;
        end else if (is_stats) begin
            stg_d.op = OP_STATS;
        end
    end

    // Next configuration from an accepted CONFIG
    always_comb begin
        mode_d   = mode_q;
        thresh_d = thresh_q;
        if (is_config) begin
            mode_d   = gray_mode_e'(valueA[1:0]);
            thresh_d = valueA[15:8];
        end
    end

    // Configuration registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= MODE_BT601;
            thresh_q <= THRESH_RST;
        end else begin
            mode_q   <= mode_d;
            thresh_q <= thresh_d;
        end
    end

    // Shift pipeline; reset drops every in-flight op
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stg_q[i] <= '0;
        end else begin
            stg_q[0] <= stg_d;
            for (int i = 1; i < PIPE_DEPTH; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign fin = stg_q[PIPE_DEPTH-1];

`ifdef GRAY_STATS_EN
    logic [31:0] sum_q, sum_d;

    // Accumulate at the last stage so STATS sees exactly the earlier CONVERTs
    always_comb begin
        sum_d = sum_q;
        if (fin.valid && fin.op == OP_CONVERT)
            sum_d = sum_q + {24'd0, fin.data[7:0]} + {24'd0, fin.data[15:8]}
                          + {24'd0, fin.data[23:16]} + {24'd0, fin.data[31:24]};
        else if (fin.valid && fin.op == OP_STATS && fin.clr)
            sum_d = '0;
    end

    // Accumulator register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    // Final-stage result: STATS reads the accumulator, others carry their data
    always_comb begin
        result_c = '0;
        if (fin.valid) result_c = (fin.op == OP_STATS) ? sum_q : fin.data;
    end
`else
    logic [2:0] unused_stats;
    assign unused_stats = {fin.op, fin.clr};

    // Final-stage result: CONFIG and STATS slots carry zero data
    always_comb begin
        result_c = '0;
        if (fin.valid) result_c = fin.data;
    end
`endif

    assign done   = fin.valid;
    assign result = result_c;

endmodule
